// File: rtl/simon_seq_gen.sv
// Simon-style colour sequence store and player: LFSR-coloured appends, timed LED playback.
// rd_color has 1-cycle latency; requests arriving while busy are dropped.
module simon_seq_gen #(
    parameter int          TICKS   = 25000000,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          MAX_LEN = 32
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       append,
    input  logic       play,
    input  logic       clear,
    input  logic [4:0] rd_idx,
    output logic [1:0] rd_color,
    output logic [3:0] led,
    output logic [5:0] len,
    output logic       busy,
    output logic       full,
    output logic       play_done
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [5:0]  CAP      = 6'(MAX_LEN);
    localparam int          TW       = 27;
    localparam logic [TW-1:0] TICKS_M1 = TW'(TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      len_q, len_d;
    logic [5:0]      idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            pend_q, pend_d;
    logic [1:0]      rd_color_q, rd_color_d;
    logic [1:0]      seq_q [32];
    logic [1:0]      seq_d [32];
    logic            full_w;

    assign full_w = (len_q == CAP);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        pend_d     = pend_q;
        seq_d      = seq_q;
        lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        rd_color_d = seq_q[rd_idx];

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    // play that arrived with an append: start now that the entry is stored
                    pend_d  = 1'b0;
                    state_d = S_ON;
                    idx_d   = 6'd0;
                    timer_d = '0;
                end else if (clear) begin
                    len_d = 6'd0;
                end else if (append && !full_w) begin
                    seq_d[len_q[4:0]] = lfsr_q[1:0];
                    len_d             = len_q + 6'd1;
                    pend_d            = play;
                end else if (play) begin
                    idx_d   = 6'd0;
                    timer_d = '0;
                    state_d = (len_q == 6'd0) ? S_DONE : S_ON;
                end
            end
            S_ON: begin
                if (timer_q == TICKS_M1) begin
                    timer_d = '0;
                    state_d = S_OFF;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_OFF: begin
                if (timer_q == TICKS_M1) begin
                    timer_d = '0;
                    idx_d   = idx_q + 6'd1;
                    state_d = ((idx_q + 6'd1) == len_q) ? S_DONE : S_ON;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= 6'd0;
            idx_q      <= 6'd0;
            timer_q    <= '0;
            lfsr_q     <= SEED_EFF;
            pend_q     <= 1'b0;
            rd_color_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            lfsr_q     <= lfsr_d;
            pend_q     <= pend_d;
            rd_color_q <= rd_color_d;
        end
    end

    // Sequence storage is not cleared by reset; len alone defines valid entries.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            seq_q <= seq_d;
        end
    end

    assign led       = (state_q == S_ON) ? (4'b0001 << seq_q[idx_q[4:0]]) : 4'b0000;
    assign rd_color  = rd_color_q;
    assign len       = len_q;
    assign busy      = (state_q != S_IDLE);
    assign full      = full_w;
    assign play_done = (state_q == S_DONE);

endmodule
